// File: rtl/arm_hazard_pkg.sv
// Shared types and constants for the ARM 5-stage pipeline hazard controller.
package arm_hazard_pkg;

  localparam int unsigned REG_W = 4;
  localparam logic [REG_W-1:0] PC_REG = 4'd15;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FAULT    = 2'b10
  } hz_state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding source select for one Execute operand; Memory stage beats Writeback.
module hazard_fwd_sel
  import arm_hazard_pkg::*;
(
  input  logic [REG_W-1:0] ra,
  input  logic [REG_W-1:0] wa_m,
  input  logic [REG_W-1:0] wa_w,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  output logic [1:0]       fwd_c
);

  always_comb begin
    fwd_c = FWD_RF;
    if (reg_write_m && (ra == wa_m)) begin
      fwd_c = FWD_M;
    end else if (reg_write_w && (ra == wa_w)) begin
      fwd_c = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, stall/flush merge and data-memory wait FSM with watchdog.
// Optional HZ_PERF_CNT_EN adds saturating stall/flush/mem-wait performance counters.
module hazard_ctrl
  import arm_hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
`ifdef HZ_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] RA1D,
  input  logic [REG_W-1:0] RA2D,
  input  logic [REG_W-1:0] RA1E,
  input  logic [REG_W-1:0] RA2E,
  input  logic [REG_W-1:0] WA3E,
  input  logic [REG_W-1:0] WA3M,
  input  logic [REG_W-1:0] WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemToRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             mem_req_m,
  input  logic             mem_ready,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_fault
`ifdef HZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] mem_wait_cycles
`endif
);

  localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT);

  hz_state_t         state;
  hz_state_t         state_next;
  logic [WCNT_W-1:0] wait_cnt;
  logic [WCNT_W-1:0] wait_cnt_next;

  logic [1:0] fwd_a_c;
  logic [1:0] fwd_b_c;
  logic       mem_stall_c;
  logic       ldr_stall_c;
  logic       pc_pend_c;

  hazard_fwd_sel u_fwd_a (
    .ra          (RA1E),
    .wa_m        (WA3M),
    .wa_w        (WA3W),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd_c       (fwd_a_c)
  );

  hazard_fwd_sel u_fwd_b (
    .ra          (RA2E),
    .wa_m        (WA3M),
    .wa_w        (WA3W),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd_c       (fwd_b_c)
  );

  // A dropped request in MEM_WAIT counts as completion; FAULT no longer tracks memory.
  assign mem_stall_c = (state != FAULT) && mem_req_m && !mem_ready;
  assign ldr_stall_c = MemToRegE && ((RA1D == WA3E) || (RA2D == WA3E));
  assign pc_pend_c   = PCSrcD || PCSrcE || PCSrcM;
  assign mem_fault   = (state == FAULT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // wait_cnt holds the number of stalled cycles already spent on the current access.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      RUN: begin
        if (mem_stall_c) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_stall_c) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt == WCNT_W'(MEM_TIMEOUT - 1)) begin
          state_next = FAULT;
        end else begin
          wait_cnt_next = wait_cnt + WCNT_W'(1);
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Priority: reset, then FAULT, then memory stall, then load-use/branch hazards.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (!reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (state == FAULT) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (mem_stall_c) begin
      ForwardAE = fwd_a_c;
      ForwardBE = fwd_b_c;
      StallF    = 1'b1;
      StallD    = 1'b1;
      StallE    = 1'b1;
      StallM    = 1'b1;
      FlushW    = 1'b1;
    end else begin
      ForwardAE = fwd_a_c;
      ForwardBE = fwd_b_c;
      StallF    = ldr_stall_c || pc_pend_c;
      StallD    = ldr_stall_c;
      FlushD    = pc_pend_c || PCSrcW || BranchTakenE;
      FlushE    = ldr_stall_c || BranchTakenE;
    end
  end

`ifdef HZ_PERF_CNT_EN
  // Saturating event counters, sampled from the merged hazard outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles    <= '0;
      flush_count     <= '0;
      mem_wait_cycles <= '0;
    end else begin
      if (StallF && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if ((FlushD || FlushE) && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
      if (mem_stall_c && (mem_wait_cycles != '1)) begin
        mem_wait_cycles <= mem_wait_cycles + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_hazard_ctrl;
  import arm_hazard_pkg::*;

  localparam int unsigned TIMEOUT = 16;
  localparam longint CMAX = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] RA1D = '0, RA2D = '0, RA1E = '0, RA2E = '0;
  logic [3:0] WA3E = '0, WA3M = '0, WA3W = '0;
  logic RegWriteM = 1'b0, RegWriteW = 1'b0, MemToRegE = 1'b0;
  logic PCSrcD = 1'b0, PCSrcE = 1'b0, PCSrcM = 1'b0, PCSrcW = 1'b0;
  logic BranchTakenE = 1'b0, mem_req_m = 1'b0, mem_ready = 1'b0;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_fault;
`ifdef HZ_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count, mem_wait_cycles;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemToRegE(MemToRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .mem_req_m(mem_req_m), .mem_ready(mem_ready),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .mem_fault(mem_fault)
`ifdef HZ_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count), .mem_wait_cycles(mem_wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] fa, fb;
    logic sf, sd, se, sm, fd, fe, fw, fault;
    longint sc, fc, mc;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Behavioural model: length of the current run of unserved memory cycles and a sticky fault.
  int run_len = 0;
  bit faulted = 1'b0;
  longint m_sc = 0, m_fc = 0, m_mc = 0;

  function automatic logic [1:0] ref_fwd(input logic [3:0] ra);
    if (RegWriteM && ra == WA3M) return 2'b10;
    if (RegWriteW && ra == WA3W) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic ref_mem_stall();
    return !faulted && mem_req_m && !mem_ready;
  endfunction

  function automatic exp_t ref_now();
    exp_t e;
    logic ldr, pcp;
    e.fa = 2'b00; e.fb = 2'b00;
    {e.sf, e.sd, e.se, e.sm, e.fd, e.fe, e.fw} = 7'b0;
    e.fault = faulted;
    e.sc = m_sc; e.fc = m_fc; e.mc = m_mc;
    e.cyc = cyc;
    ldr = MemToRegE && (RA1D == WA3E || RA2D == WA3E);
    pcp = PCSrcD || PCSrcE || PCSrcM;
    if (!reset) begin
      e.fd = 1'b1; e.fe = 1'b1; e.fw = 1'b1;
    end else if (faulted) begin
      {e.sf, e.sd, e.se, e.sm, e.fw} = 5'b11111;
    end else begin
      e.fa = ref_fwd(RA1E);
      e.fb = ref_fwd(RA2E);
      if (ref_mem_stall()) begin
        {e.sf, e.sd, e.se, e.sm, e.fw} = 5'b11111;
      end else begin
        e.sf = ldr || pcp;
        e.sd = ldr;
        e.fd = pcp || PCSrcW || BranchTakenE;
        e.fe = ldr || BranchTakenE;
      end
    end
    return e;
  endfunction

  function automatic longint sat_inc(input longint v, input logic en);
    return (en && v < CMAX) ? v + 1 : v;
  endfunction

  // Inputs are already applied: queue the expectation, then advance the model across the edge.
  task automatic cycle();
    exp_t e;
    logic ms;
    e = ref_now();
    ms = ref_mem_stall();
    exp_q.push_back(e);
    @(posedge clk);
    if (!reset) begin
      run_len = 0; faulted = 1'b0; m_sc = 0; m_fc = 0; m_mc = 0;
    end else begin
      m_sc = sat_inc(m_sc, e.sf);
      m_fc = sat_inc(m_fc, e.fd || e.fe);
      m_mc = sat_inc(m_mc, ms);
      if (!faulted) begin
        if (ms) begin
          run_len++;
          if (run_len >= TIMEOUT) faulted = 1'b1;
        end else begin
          run_len = 0;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    {RegWriteM, RegWriteW, MemToRegE, PCSrcD, PCSrcE, PCSrcM, PCSrcW} = '0;
    {BranchTakenE, mem_req_m, mem_ready} = '0;
    reset = 1'b1;
  endtask

  task automatic rand_in(input int ready_pct);
    RA1D = 4'($urandom_range(0, 7)); RA2D = 4'($urandom_range(0, 7));
    RA1E = 4'($urandom_range(0, 7)); RA2E = 4'($urandom_range(0, 7));
    WA3E = 4'($urandom_range(0, 7)); WA3M = 4'($urandom_range(0, 7));
    WA3W = 4'($urandom_range(0, 7));
    RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
    MemToRegE = 1'($urandom_range(0, 3) == 0);
    PCSrcD = 1'($urandom_range(0, 9) == 0); PCSrcE = 1'($urandom_range(0, 9) == 0);
    PCSrcM = 1'($urandom_range(0, 9) == 0); PCSrcW = 1'($urandom_range(0, 9) == 0);
    BranchTakenE = 1'($urandom_range(0, 7) == 0);
    mem_req_m = 1'($urandom_range(0, 3) != 0);
    mem_ready = 1'($urandom_range(0, 99) < ready_pct);
    reset = 1'($urandom_range(0, 149) != 0);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req, input int c);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("ForwardAE", 64'(ForwardAE), 64'(e.fa), e.cyc);
      chk("ForwardBE", 64'(ForwardBE), 64'(e.fb), e.cyc);
      chk("StallF", 64'(StallF), 64'(e.sf), e.cyc);
      chk("StallD", 64'(StallD), 64'(e.sd), e.cyc);
      chk("StallE", 64'(StallE), 64'(e.se), e.cyc);
      chk("StallM", 64'(StallM), 64'(e.sm), e.cyc);
      chk("FlushD", 64'(FlushD), 64'(e.fd), e.cyc);
      chk("FlushE", 64'(FlushE), 64'(e.fe), e.cyc);
      chk("FlushW", 64'(FlushW), 64'(e.fw), e.cyc);
      chk("mem_fault", 64'(mem_fault), 64'(e.fault), e.cyc);
`ifdef HZ_PERF_CNT_EN
      chk("stall_cycles", 64'(stall_cycles), 64'(e.sc), e.cyc);
      chk("flush_count", 64'(flush_count), 64'(e.fc), e.cyc);
      chk("mem_wait_cycles", 64'(mem_wait_cycles), 64'(e.mc), e.cyc);
`endif
    end
  end

  initial begin
    int pct;
    reset = 1'b0;
    @(posedge clk);
    #1;
    cycle(); cycle();

    // Forwarding priority.
    idle();
    RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1;
    cycle();
    RegWriteM = 1'b0;
    cycle();

    // Load-use stall for one cycle.
    idle();
    MemToRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; RA1D = 4'd1;
    cycle();
    MemToRegE = 1'b0;
    cycle();

    // Taken branch, then PC write walking down D/E/M, then W.
    idle(); BranchTakenE = 1'b1; cycle();
    idle(); PCSrcD = 1'b1; cycle();
    idle(); PCSrcE = 1'b1; cycle();
    idle(); PCSrcM = 1'b1; cycle();
    idle(); PCSrcW = 1'b1; cycle();

    // Three wait cycles, then completion.
    idle(); mem_req_m = 1'b1;
    repeat (3) cycle();
    mem_ready = 1'b1; cycle();
    idle(); cycle();
    // Ready without request is ignored.
    mem_ready = 1'b1; cycle();

    // Watchdog expiry, sticky fault, reset recovery.
    idle(); mem_req_m = 1'b1; RA1E = 4'd2; WA3M = 4'd2; RegWriteM = 1'b1;
    repeat (TIMEOUT + 4) cycle();
    mem_ready = 1'b1; cycle();
    reset = 1'b0; cycle();
    idle(); cycle(); cycle();

    // Fault exactly at the boundary: one ready cycle short of it must not fault.
    idle(); mem_req_m = 1'b1;
    repeat (TIMEOUT - 1) cycle();
    mem_ready = 1'b1; cycle();
    mem_ready = 1'b0;
    repeat (TIMEOUT + 1) cycle();
    reset = 1'b0; cycle();

    // Reset during MEM_WAIT; request dropping also ends a wait.
    idle(); mem_req_m = 1'b1;
    repeat (3) cycle();
    reset = 1'b0; cycle();
    idle(); cycle();
    mem_req_m = 1'b1; cycle(); cycle();
    mem_req_m = 1'b0; cycle();

    // Randomized traffic with varying memory speed.
    for (int blk = 0; blk < 24; blk++) begin
      case (blk % 3)
        0: pct = 90;
        1: pct = 50;
        default: pct = 3;
      endcase
      for (int i = 0; i < 100; i++) begin
        rand_in(pct);
        cycle();
      end
    end

    idle();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
